// File: rtl/implication_queue.sv
// Implication FIFO between the unit-clause evaluator and the trail logic.
// A per-variable pending map drops duplicate implications and flags opposite-valued ones as conflicts.
module implication_queue #(
  parameter int unsigned NUM_VARIABLE   = 128,
  parameter int unsigned VARIABLE_INDEX = 6,
  parameter int unsigned DEPTH          = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_valid,
  input  logic [VARIABLE_INDEX:0]   push_var,
  input  logic                      push_val,
  output logic                      push_ready,
  output logic                      pop_valid,
  input  logic                      pop_ready,
  output logic [VARIABLE_INDEX:0]   pop_var,
  output logic                      pop_val,
  input  logic                      flush,
  output logic                      conflict,
  output logic [VARIABLE_INDEX:0]   conflict_var,
  output logic [$clog2(DEPTH):0]    count,
  output logic [7:0]                dup_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned VAR_W = VARIABLE_INDEX + 1;

  typedef enum logic {RUN, CONFLICT} state_t;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [NUM_VARIABLE-1:0]   pend_q, pend_d;
  logic [NUM_VARIABLE-1:0]   pend_val_q, pend_val_d;
  logic                      conflict_q, conflict_d;
  logic [VAR_W-1:0]          conflict_var_q, conflict_var_d;
  logic [7:0]                dup_count_q, dup_count_d;
  logic [VAR_W-1:0]          mem_var_q [DEPTH];
  logic [VAR_W-1:0]          mem_var_d [DEPTH];
  logic                      mem_val_q [DEPTH];
  logic                      mem_val_d [DEPTH];

  logic push_fire, pop_fire, pend_hit, do_write, do_dup, do_conflict;

  assign push_ready   = (state_q == RUN) && (count_q != CNT_W'(DEPTH));
  assign pop_valid    = (state_q == RUN) && (count_q != '0);
  assign pop_var      = mem_var_q[rd_ptr_q];
  assign pop_val      = mem_val_q[rd_ptr_q];
  assign conflict     = conflict_q;
  assign conflict_var = conflict_var_q;
  assign count        = count_q;
  assign dup_count    = dup_count_q;

  // Pending lookup uses the map as it stood before this cycle's pop clear.
  assign push_fire   = push_valid && push_ready && !flush;
  assign pop_fire    = pop_valid && pop_ready && !flush;
  assign pend_hit    = pend_q[push_var];
  assign do_write    = push_fire && !pend_hit;
  assign do_dup      = push_fire && pend_hit && (pend_val_q[push_var] == push_val);
  assign do_conflict = push_fire && pend_hit && (pend_val_q[push_var] != push_val);

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    pend_d         = pend_q;
    pend_val_d     = pend_val_q;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    dup_count_d    = dup_count_q;
    mem_var_d      = mem_var_q;
    mem_val_d      = mem_val_q;

    if (flush) begin
      state_d        = RUN;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      pend_d         = '0;
      pend_val_d     = '0;
      conflict_d     = 1'b0;
      conflict_var_d = '0;
    end else begin
      if (pop_fire) begin
        rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        pend_d[pop_var]  = 1'b0;
      end
      if (do_write) begin
        mem_var_d[wr_ptr_q]  = push_var;
        mem_val_d[wr_ptr_q]  = push_val;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        pend_d[push_var]     = 1'b1;
        pend_val_d[push_var] = push_val;
      end
      if (do_dup && (dup_count_q != 8'hFF)) begin
        dup_count_d = dup_count_q + 8'd1;
      end
      if (do_conflict) begin
        conflict_d     = 1'b1;
        conflict_var_d = push_var;
        state_d        = CONFLICT;
      end
      count_d = count_q + CNT_W'(do_write) - CNT_W'(pop_fire);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pend_q         <= '0;
      pend_val_q     <= '0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
      dup_count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_var_q[i] <= '0;
        mem_val_q[i] <= 1'b0;
      end
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      pend_q         <= pend_d;
      pend_val_q     <= pend_val_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
      dup_count_q    <= dup_count_d;
      mem_var_q      <= mem_var_d;
      mem_val_q      <= mem_val_d;
    end
  end

endmodule

// File: tb/tb_implication_queue.sv
// Directed bench for implication_queue: ordering, duplicate drop, conflict, full, same-cycle push/pop, async reset.
module tb_implication_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       push_valid;
  logic [6:0] push_var;
  logic       push_val;
  logic       push_ready;
  logic       pop_valid;
  logic       pop_ready;
  logic [6:0] pop_var;
  logic       pop_val;
  logic       flush;
  logic       conflict;
  logic [6:0] conflict_var;
  logic [4:0] count;
  logic [7:0] dup_count;

  int checks = 0;
  int errors = 0;

  implication_queue dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_var(push_var), .push_val(push_val), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_var(pop_var), .pop_val(pop_val),
    .flush(flush), .conflict(conflict), .conflict_var(conflict_var),
    .count(count), .dup_count(dup_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [6:0] v, input logic b);
    push_valid = 1'b1; push_var = v; push_val = b;
    cycle();
    push_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [6:0] v, input logic b);
    #1;
    chk({tag, "_valid"}, 32'(pop_valid), 32'd1);
    chk({tag, "_var"}, 32'(pop_var), 32'(v));
    chk({tag, "_val"}, 32'(pop_val), 32'(b));
    pop_ready = 1'b1;
    cycle();
    pop_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push_valid = 1'b0; push_var = '0; push_val = 1'b0;
    pop_ready = 1'b0; flush = 1'b0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    chk("rst_dup", 32'(dup_count), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();

    // 1: FIFO ordering
    push(7'd5, 1'b1); push(7'd9, 1'b0); push(7'd12, 1'b1);
    chk("t1_count3", 32'(count), 32'd3);
    pop_expect("t1_pop0", 7'd5, 1'b1);
    pop_expect("t1_pop1", 7'd9, 1'b0);
    pop_expect("t1_pop2", 7'd12, 1'b1);
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_pop_valid", 32'(pop_valid), 32'd0);

    // 2: duplicate drop (var 5 pending cleared by the earlier pop)
    push(7'd5, 1'b1); push(7'd5, 1'b1);
    chk("t2_count", 32'(count), 32'd1);
    chk("t2_dup", 32'(dup_count), 32'd1);
    pop_expect("t2_pop", 7'd5, 1'b1);
    chk("t2_count0", 32'(count), 32'd0);

    // 3: conflict, then flush with an ignored push
    push(7'd7, 1'b1); push(7'd7, 1'b0);
    chk("t3_conflict", 32'(conflict), 32'd1);
    chk("t3_cvar", 32'(conflict_var), 32'd7);
    chk("t3_push_ready", 32'(push_ready), 32'd0);
    chk("t3_pop_valid", 32'(pop_valid), 32'd0);
    chk("t3_count", 32'(count), 32'd1);
    push_valid = 1'b1; push_var = 7'd8; push_val = 1'b1;
    do_flush();
    push_valid = 1'b0;
    chk("t3_flush_conflict", 32'(conflict), 32'd0);
    chk("t3_flush_count", 32'(count), 32'd0);
    chk("t3_flush_ready", 32'(push_ready), 32'd1);
    chk("t3_dup_kept", 32'(dup_count), 32'd1);

    // 4: fill to full, reject 17th, pop frees a slot
    for (int i = 0; i < 16; i++) push(7'(20 + i), 1'(i));
    chk("t4_count16", 32'(count), 32'd16);
    chk("t4_full_ready", 32'(push_ready), 32'd0);
    push_valid = 1'b1; push_var = 7'd40; push_val = 1'b1;
    cycle();
    push_valid = 1'b0;
    chk("t4_no_take", 32'(count), 32'd16);
    pop_expect("t4_head", 7'd20, 1'b0);
    chk("t4_ready_after_pop", 32'(push_ready), 32'd1);
    chk("t4_count15", 32'(count), 32'd15);
    chk("t4_next_var", 32'(pop_var), 32'd21);
    chk("t4_next_val", 32'(pop_val), 32'd1);
    do_flush();

    // 5: same-variable pop and opposite push in one cycle
    push(7'd3, 1'b0);
    push_valid = 1'b1; push_var = 7'd3; push_val = 1'b1;
    pop_expect("t5_head", 7'd3, 1'b0);
    push_valid = 1'b0;
    chk("t5_conflict", 32'(conflict), 32'd1);
    chk("t5_cvar", 32'(conflict_var), 32'd3);
    chk("t5_count", 32'(count), 32'd0);
    do_flush();

    // 6: async reset mid-operation
    push(7'd1, 1'b1); push(7'd1, 1'b1);
    push(7'd2, 1'b0); push(7'd4, 1'b1); push(7'd6, 1'b0);
    chk("t6_count4", 32'(count), 32'd4);
    chk("t6_dup2", 32'(dup_count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_dup", 32'(dup_count), 32'd0);
    chk("t6_pop_valid", 32'(pop_valid), 32'd0);
    chk("t6_pop_var", 32'(pop_var), 32'd0);
    chk("t6_push_ready", 32'(push_ready), 32'd1);
    chk("t6_conflict", 32'(conflict), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
